// File: rtl/nn_output_collector_pkg.sv
// -----------------------------------------------------------------------------
// nn_output_collector_pkg
// Shared definitions for the neuroNoC output collector: packet field widths,
// packet type codes, the packed packet layout, FSM state encoding and a small
// saturating-increment helper.
// -----------------------------------------------------------------------------
package nn_output_collector_pkg;

    // Packet field widths; a packet is {type, seq, dest, source, payload}, MSB first.
    localparam int TYPE_WIDTH    = 3;
    localparam int SEQ_WIDTH     = 8;
    localparam int DEST_WIDTH    = 8;
    localparam int SOURCE_WIDTH  = 8;
    localparam int PAYLOAD_WIDTH = 16;
    localparam int PACKET_SIZE   = TYPE_WIDTH + SEQ_WIDTH + DEST_WIDTH
                                 + SOURCE_WIDTH + PAYLOAD_WIDTH;

    // Host-side widths.
    localparam int RD_ADDR_W = 6;   // readout index / neuron index
    localparam int COUNT_W   = 6;   // distinct neurons received
    localparam int SAT_W     = 8;   // drop / duplicate counters
    localparam int TIMER_W   = 16;  // idle-cycle timer

    // Packet type codes.
    localparam logic [TYPE_WIDTH-1:0] PKT_DATA     = 3'd0;
    localparam logic [TYPE_WIDTH-1:0] PKT_CONF_W   = 3'd1;
    localparam logic [TYPE_WIDTH-1:0] PKT_CONF_INB = 3'd2;
    localparam logic [TYPE_WIDTH-1:0] PKT_CONF_FT  = 3'd3;

    typedef struct packed {
        logic [TYPE_WIDTH-1:0]    ptype;
        logic [SEQ_WIDTH-1:0]     seq;
        logic [DEST_WIDTH-1:0]    dest;
        logic [SOURCE_WIDTH-1:0]  source;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } nn_packet_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } collector_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/nn_output_collector_ram.sv
// -----------------------------------------------------------------------------
// nn_result_ram
// Result storage for the output collector: DEPTH x WIDTH, one write port and
// one synchronous read port sharing the same clock. A read and a write to the
// same address in one cycle return the previously stored word.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable (rdata holds its value when low)
//   raddr  read address
//   rdata  registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module nn_result_ram #(
    parameter int DEPTH  = 48,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; validity of each
    // word is tracked by the bitmap in the top level, not by clearing contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/nn_output_collector.sv
// -----------------------------------------------------------------------------
// nn_output_collector
// Host-side receiver at the neuroNoC output port. Sinks packets, decodes
// {type, seq, dest, source, payload}, stores output-layer DATA results per
// neuron and flags round completion (all neurons seen, or idle timeout).
// Stored results are readable by random access in every state.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   nn_valid/nn_ready NoC output-port handshake (ready low only in DONE)
//   nn_data           packet {type, seq, dest, source, payload}
//   start, expect_seq arm a new round; expected seq sampled with start
//   busy, done        state == COLLECT / state == DONE
//   timeout           round ended by timeout (sticky until next start)
//   rx_count          distinct neurons received this round
//   drop_count        discarded packets (saturating)
//   dup_count         duplicate-source packets (saturating)
//   rd_addr           readout neuron index
//   rd_data, rd_hit   stored payload / presence flag (1-cycle latency)
// -----------------------------------------------------------------------------
module nn_output_collector
    import nn_output_collector_pkg::*;
#(
    parameter int OUT_BASE       = 208,
    parameter int NUM_OUTPUTS    = 48,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     nn_valid,
    output logic                     nn_ready,
    input  logic [PACKET_SIZE-1:0]   nn_data,
    input  logic                     start,
    input  logic [SEQ_WIDTH-1:0]     expect_seq,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout,
    output logic [COUNT_W-1:0]       rx_count,
    output logic [SAT_W-1:0]         drop_count,
    output logic [SAT_W-1:0]         dup_count,
    input  logic [RD_ADDR_W-1:0]     rd_addr,
    output logic [PAYLOAD_WIDTH-1:0] rd_data,
    output logic                     rd_hit
);

    // Source range is checked one bit wider than the field so that
    // OUT_BASE + NUM_OUTPUTS = 256 is representable (no modulo wrap).
    localparam logic [SOURCE_WIDTH:0]  BASE_EXT     = (SOURCE_WIDTH+1)'(OUT_BASE);
    localparam logic [SOURCE_WIDTH:0]  NUM_EXT      = (SOURCE_WIDTH+1)'(NUM_OUTPUTS);
    localparam logic [COUNT_W-1:0]     LAST_COUNT   = COUNT_W'(NUM_OUTPUTS - 1);
    localparam logic [RD_ADDR_W-1:0]   NUM_ADDR     = RD_ADDR_W'(NUM_OUTPUTS);
    localparam logic [TIMER_W-1:0]     TIMEOUT_LAST =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    collector_state_e           state_q, state_d;
    logic [NUM_OUTPUTS-1:0]     bitmap_q;
    logic [COUNT_W-1:0]         rx_count_q;
    logic [SAT_W-1:0]           drop_count_q, dup_count_q;
    logic [TIMER_W-1:0]         timer_q;
    logic                       timeout_q;
    logic [SEQ_WIDTH-1:0]       exp_seq_q;
    logic                       rd_hit_q;

    // ---------------------------------------------------------------- decode
    nn_packet_t                 pkt;
    logic [SOURCE_WIDTH:0]      src_ext, src_off;
    logic [RD_ADDR_W-1:0]       wr_idx;
    logic                       src_in_range, is_match, bit_set;
    logic                       dest_unused;

    assign pkt          = nn_packet_t'(nn_data);
    assign dest_unused  = ^pkt.dest;   // destination is not used by the host
    assign src_ext      = {1'b0, pkt.source};
    assign src_off      = src_ext - BASE_EXT;
    assign src_in_range = (src_ext >= BASE_EXT) && (src_off < NUM_EXT);
    assign wr_idx       = src_off[RD_ADDR_W-1:0];
    assign is_match     = (pkt.ptype == PKT_DATA) && (pkt.seq == exp_seq_q) && src_in_range;
    assign bit_set      = src_in_range && bitmap_q[wr_idx];

    // ------------------------------------------------------------ handshake
    logic xfer, pkt_live, collect_xfer;
    logic accept_new, accept_dup, drop_pkt, timer_hit, last_accept;

    assign nn_ready     = (state_q != ST_DONE);
    assign xfer         = nn_valid && nn_ready;
    // A packet arriving with start is swallowed: start wins.
    assign pkt_live     = xfer && !start;
    assign collect_xfer = pkt_live && (state_q == ST_COLLECT);
    assign accept_new   = collect_xfer && is_match && !bit_set;
    assign accept_dup   = collect_xfer && is_match && bit_set;
    assign drop_pkt     = pkt_live && ((state_q == ST_IDLE) || !is_match);
    assign last_accept  = accept_new && (rx_count_q == LAST_COUNT);
    assign timer_hit    = (TIMEOUT_CYCLES != 0) && (state_q == ST_COLLECT)
                        && !xfer && !start && (timer_q == TIMEOUT_LAST);

    // ------------------------------------------------------------------ FSM
    // NOTE: sequential blocks use non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_COLLECT;
        end else begin
            case (state_q)
                ST_COLLECT: if (last_accept || timer_hit) state_d = ST_DONE;
                default:    state_d = state_q;
            endcase
        end
    end

    // ------------------------------------------- bitmap, counters and timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap_q     <= '0;
            rx_count_q   <= '0;
            drop_count_q <= '0;
            dup_count_q  <= '0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            exp_seq_q    <= '0;
        end else if (start) begin
            bitmap_q     <= '0;
            rx_count_q   <= '0;
            drop_count_q <= '0;
            dup_count_q  <= '0;
            timer_q      <= '0;
            timeout_q    <= 1'b0;
            exp_seq_q    <= expect_seq;
        end else begin
            if (accept_new) begin
                bitmap_q[wr_idx] <= 1'b1;
                rx_count_q       <= rx_count_q + 1'b1;
            end
            if (accept_dup) begin
                dup_count_q <= sat_inc(dup_count_q);
            end
            if (drop_pkt) begin
                drop_count_q <= sat_inc(drop_count_q);
            end
            if (state_q == ST_COLLECT) begin
                if (xfer) begin
                    timer_q <= '0;
                end else if (timer_hit) begin
                    timer_q   <= '0;
                    timeout_q <= 1'b1;
                end else begin
                    timer_q <= timer_q + 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------- readout
    logic                     rd_in_range;
    logic [PAYLOAD_WIDTH-1:0] ram_rdata;

    assign rd_in_range = (rd_addr < NUM_ADDR);

    nn_result_ram #(
        .DEPTH  (NUM_OUTPUTS),
        .WIDTH  (PAYLOAD_WIDTH),
        .ADDR_W (RD_ADDR_W)
    ) u_result_ram (
        .clk   (clk),
        .we    (accept_new),
        .waddr (wr_idx),
        .wdata (pkt.payload),
        .re    (rd_in_range),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // The hit flag samples the bitmap before this cycle's write, matching the
    // RAM's read-before-write behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_hit_q <= 1'b0;
        end else begin
            rd_hit_q <= rd_in_range && bitmap_q[rd_addr];
        end
    end

    // RAM words without a valid bit read as zero, so stale contents never leak.
    assign rd_data    = rd_hit_q ? ram_rdata : '0;
    assign rd_hit     = rd_hit_q;

    assign busy       = (state_q == ST_COLLECT);
    assign done       = (state_q == ST_DONE);
    assign timeout    = timeout_q;
    assign rx_count   = rx_count_q;
    assign drop_count = drop_count_q;
    assign dup_count  = dup_count_q;

endmodule

// File: tb/tb_nn_output_collector.sv
// -----------------------------------------------------------------------------
// tb_nn_output_collector
// Directed bench for nn_output_collector with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_nn_output_collector;
    import nn_output_collector_pkg::*;

    localparam int BASE = 208;
    localparam int NUM  = 48;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     nn_valid = 1'b0;
    logic                     nn_ready;
    logic [PACKET_SIZE-1:0]   nn_data = '0;
    logic                     start = 1'b0;
    logic [SEQ_WIDTH-1:0]     expect_seq = '0;
    logic                     busy, done, timeout;
    logic [COUNT_W-1:0]       rx_count;
    logic [SAT_W-1:0]         drop_count, dup_count;
    logic [RD_ADDR_W-1:0]     rd_addr = '0;
    logic [PAYLOAD_WIDTH-1:0] rd_data;
    logic                     rd_hit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nn_output_collector #(
        .OUT_BASE       (BASE),
        .NUM_OUTPUTS    (NUM),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nn_valid   (nn_valid),
        .nn_ready   (nn_ready),
        .nn_data    (nn_data),
        .start      (start),
        .expect_seq (expect_seq),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .rx_count   (rx_count),
        .drop_count (drop_count),
        .dup_count  (dup_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit)
    );

    task automatic check(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present one packet for one clock edge.
    task automatic send_pkt(input logic [TYPE_WIDTH-1:0] t, input int seq,
                            input int src, input int pay, input int dst = 0);
        nn_valid = 1'b1;
        nn_data  = {t, 8'(seq), 8'(dst), 8'(src), 16'(pay)};
        @(negedge clk);
        nn_valid = 1'b0;
    endtask

    task automatic do_start(input int seq);
        start      = 1'b1;
        expect_seq = 8'(seq);
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic rd(input int addr, output int data, output int hit);
        rd_addr = 6'(addr);
        @(negedge clk);
        data = int'(rd_data);
        hit  = int'(rd_hit);
    endtask

    initial begin
        int d, h, hits;

        // ---------------- reset state
        repeat (2) @(negedge clk);
        check("rst_ready", nn_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_rx", rx_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_dup", dup_count, 0);
        check("rst_rdhit", rd_hit, 0);
        check("rst_rddata", rd_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- 1: reset mid-COLLECT after 10 accepts
        do_start(1);
        for (int i = 0; i < 10; i++) send_pkt(PKT_DATA, 1, BASE + i, i + 1);
        check("t1_rx10", rx_count, 10);
        check("t1_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t1_busy_after_rst", busy, 0);
        check("t1_rx_after_rst", rx_count, 0);
        check("t1_ready_after_rst", nn_ready, 1);
        rst = 1'b0;
        hits = 0;
        for (int a = 0; a < NUM; a++) begin
            rd(a, d, h);
            hits += h;
        end
        check("t1_hits_after_rst", hits, 0);
        send_pkt(PKT_DATA, 1, BASE, 5);
        check("idle_drop", drop_count, 1);
        check("idle_rx", rx_count, 0);

        // ---------------- 2: full round seq=2
        do_start(2);
        check("t2_drop_cleared", drop_count, 0);
        check("t2_busy", busy, 1);
        for (int i = 0; i < NUM - 1; i++) send_pkt(PKT_DATA, 2, BASE + i, BASE + i);
        check("t2_not_done_47", done, 0);
        check("t2_rx47", rx_count, 47);
        send_pkt(PKT_DATA, 2, 255, 255);
        check("t2_done", done, 1);
        check("t2_busy_off", busy, 0);
        check("t2_ready_low", nn_ready, 0);
        check("t2_rx48", rx_count, 48);
        rd(5, d, h);
        check("t2_rd5_data", d, 213);
        check("t2_rd5_hit", h, 1);
        rd(47, d, h);
        check("t2_rd47_data", d, 255);
        rd(48, d, h);
        check("t2_rd48_hit", h, 0);
        check("t2_rd48_data", d, 0);
        send_pkt(PKT_DATA, 2, BASE, 99);
        check("t2_done_no_drop", drop_count, 0);
        rd(0, d, h);
        check("t2_frozen_rd0", d, 208);

        // ---------------- 3: mixed traffic in COLLECT (seq=5)
        do_start(5);
        send_pkt(PKT_DATA, 5, 208, 11);
        check("t3_rx1", rx_count, 1);
        send_pkt(PKT_DATA, 1, 209, 1);
        send_pkt(PKT_CONF_W, 5, 209, 2);
        send_pkt(PKT_DATA, 5, 100, 3);
        check("t3_drop3", drop_count, 3);
        check("t3_rx_unchanged", rx_count, 1);
        send_pkt(PKT_DATA, 5, 207, 4);
        check("t3_below_base_drop", drop_count, 4);
        send_pkt(PKT_DATA, 5, 211, 33, 8'h99);
        check("t3_dest_ignored", rx_count, 2);

        // ---------------- 4: duplicate source
        send_pkt(PKT_DATA, 5, 210, 7);
        send_pkt(PKT_DATA, 5, 210, 9);
        check("t4_dup1", dup_count, 1);
        check("t4_rx3", rx_count, 3);
        rd(2, d, h);
        check("t4_rd2_data", d, 7);
        check("t4_rd2_hit", h, 1);
        // read and write of index 4 in the same cycle: old (empty) value
        rd_addr = 6'd4;
        send_pkt(PKT_DATA, 5, 212, 44);
        check("t4_rbw_hit_old", rd_hit, 0);
        check("t4_rbw_data_old", rd_data, 0);
        @(negedge clk);
        check("t4_rbw_data_new", rd_data, 44);
        check("t4_rx4", rx_count, 4);

        // ---------------- 5: timeout with 47 of 48 outputs
        do_start(6);
        for (int i = 0; i < NUM; i++) begin
            if (i != 22) send_pkt(PKT_DATA, 6, BASE + i, BASE + i);
        end
        repeat (19) @(negedge clk);
        check("t5_busy_at_19", busy, 1);
        check("t5_no_timeout_19", timeout, 0);
        @(negedge clk);
        check("t5_done_at_20", done, 1);
        check("t5_timeout", timeout, 1);
        check("t5_rx47", rx_count, 47);
        rd(22, d, h);
        check("t5_missing_hit", h, 0);
        rd(21, d, h);
        check("t5_rd21_data", d, 229);
        check("t5_rd21_hit", h, 1);

        // ---------------- 6: start coinciding with a matching packet
        do_start(9);
        check("t6_timeout_cleared", timeout, 0);
        check("t6_busy", busy, 1);
        start      = 1'b1;
        expect_seq = 8'd3;
        nn_valid   = 1'b1;
        nn_data    = {PKT_DATA, 8'd3, 8'd0, 8'd208, 16'd1};
        @(negedge clk);
        start    = 1'b0;
        nn_valid = 1'b0;
        check("t6_start_rx0", rx_count, 0);
        check("t6_start_drop0", drop_count, 0);
        check("t6_start_busy", busy, 1);
        rd(0, d, h);
        check("t6_start_not_stored", h, 0);
        for (int i = 0; i < NUM; i++) send_pkt(PKT_DATA, 3, BASE + i, BASE + i + 1000);
        check("t6_seq3_done", done, 1);
        check("t6_seq3_rx", rx_count, 48);
        check("t6_seq3_dup", dup_count, 0);
        check("t6_seq3_drop", drop_count, 0);
        rd(10, d, h);
        check("t6_seq3_rd10", d, 1218);
        do_start(4);
        check("t6_seq4_busy", busy, 1);
        check("t6_seq4_rx0", rx_count, 0);
        for (int i = 0; i < NUM; i++) send_pkt(PKT_DATA, 4, BASE + i, (BASE + i) * 2);
        check("t6_seq4_done", done, 1);
        check("t6_seq4_rx", rx_count, 48);
        check("t6_seq4_timeout", timeout, 0);
        rd(47, d, h);
        check("t6_seq4_rd47", d, 510);
        rd(0, d, h);
        check("t6_seq4_rd0", d, 416);

        // ---------------- drop counter saturation (IDLE)
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 260; i++) send_pkt(PKT_CONF_FT, 0, 0, 0);
        check("sat_drop255", drop_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
